// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory answering one load/store at a time after LATENCY wait cycles
//  clk, rst        clock and asynchronous active-high reset
//  req_valid/ready request handshake; req_write, req_addr (byte, word aligned), req_wdata
//  resp_valid/ready response handshake; resp_rdata (load data, else 0), resp_err (misaligned/out of range)
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];
  logic        accept, enter_resp, cur_write, cur_err, mem_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [AW-1:0] idx;
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  always_comb begin
    accept     = req_ready & req_valid;
    enter_resp = (accept & LATENCY == 0) | (state_q == WAIT & cnt_q == 4'd0);
    // with zero latency the request is classified on its own accept edge, before capture
    cur_write  = req_ready ? req_write : write_q;
    cur_addr   = req_ready ? req_addr : addr_q;
    cur_wdata  = req_ready ? req_wdata : wdata_q;
    idx        = cur_addr[AW+1:2];
    cur_err    = (cur_addr[1:0] != 2'b00) | ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));
    mem_we     = enter_resp & cur_write & ~cur_err;
    state_d    = accept ? ((LATENCY == 0) ? RESP : WAIT)
               : enter_resp ? RESP
               : (resp_valid & resp_ready) ? IDLE : state_q;
    cnt_d      = accept ? LAT_M1 : (state_q == WAIT) ? cnt_q - 4'd1 : cnt_q;
    write_d    = accept ? req_write : write_q;
    addr_d     = accept ? req_addr : addr_q;
    wdata_d    = accept ? req_wdata : wdata_q;
    rdata_d    = enter_resp ? ((~cur_write & ~cur_err) ? mem_q[idx] : 32'd0)
               : (resp_valid & resp_ready) ? 32'd0 : rdata_q;
    err_d      = enter_resp ? cur_err : (resp_valid & resp_ready) ? 1'b0 : err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx] <= cur_wdata;
    end
  end
endmodule
